// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        FIN   = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

    // Word-count header length in bytes (little-endian).
    localparam int HDR_BYTES      = 2;
    // Bytes per instruction word (little-endian).
    localparam int BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg

// File: rtl/imem_word_assembler.sv
// Collects little-endian bytes into 32-bit words. The first three bytes are
// held in lane registers; the fourth byte is combined with them directly so
// word_valid/word_data are available in the same cycle as the final transfer.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]                   lane_reg;
    logic [BYTES_PER_WORD-2:0][7:0]      lane_bytes_reg;

    // Lane counter wraps after the last byte of each word.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_reg <= '0;
        end else if (byte_fire) begin
            lane_reg <= lane_reg + 1'b1;
        end
    end

    // One register per low lane; each captures the byte arriving in its slot.
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (reset) begin
                lane_bytes_reg[gi] <= '0;
            end else if (byte_fire && (lane_reg == LANE_W'(gi))) begin
                lane_bytes_reg[gi] <= byte_data;
            end
        end
    end

    assign word_valid = byte_fire && (lane_reg == LANE_W'(BYTES_PER_WORD - 1));
    assign word_data  = {byte_data, lane_bytes_reg};

endmodule : imem_word_assembler

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction RAM. Parses a byte stream consisting of a
// 16-bit little-endian word count followed by that many little-endian words,
// writes each word to the RAM write port and releases the core from reset
// once the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over all header and data bytes before release.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int IDX_W = $clog2(MEM_SIZE) + 1;
    localparam int CNT_W = HDR_BYTES * 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t IMAGE_END_STATE = CSUM;
`else
    localparam loader_state_t IMAGE_END_STATE = FIN;
`endif

    loader_state_t          state_reg, state_next;
    logic [CNT_W-1:0]       word_count_reg;
    logic [CNT_W-1:0]       header_count;
    logic [IDX_W-1:0]       word_index_reg;
    logic                   we_reg;
    logic [ADDR_WIDTH-1:0]  waddr_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic                   done_reg;
    logic                   byte_fire;
    logic                   asm_fire;
    logic                   word_valid;
    logic [31:0]            word_data;
    logic                   last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_reg;
`endif

    assign byte_ready = (state_reg == HDR0) || (state_reg == HDR1) ||
                        (state_reg == DATA) || (state_reg == CSUM);
    assign byte_fire  = byte_valid && byte_ready;
    assign asm_fire   = byte_fire && (state_reg == DATA);

    // Full count as seen while the high header byte is on the bus.
    assign header_count = {byte_data, word_count_reg[7:0]};
    // The word currently completing is the last one of the image.
    assign last_word    = (CNT_W'(word_index_reg) + CNT_W'(1)) == word_count_reg;

    imem_word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .byte_fire  (asm_fire),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Next-state logic for the stream parser.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: state_next = HDR0;
            HDR0: if (byte_fire) state_next = HDR1;
            HDR1: begin
                if (byte_fire) begin
                    if (header_count > CNT_W'(MEM_SIZE)) begin
                        state_next = ERROR;
                    end else if (header_count == '0) begin
                        state_next = IMAGE_END_STATE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: if (word_valid && last_word) state_next = IMAGE_END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (byte_fire) state_next = (byte_data == csum_reg) ? FIN : ERROR;
`endif
            default: state_next = state_reg;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Header capture: low byte first, full count once the high byte arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_reg <= '0;
        end else if (byte_fire && (state_reg == HDR0)) begin
            word_count_reg[7:0] <= byte_data;
        end else if (byte_fire && (state_reg == HDR1)) begin
            word_count_reg <= header_count;
        end
    end

    // Write port: register address/data of each completed word and pulse the
    // strobe for one cycle; the word index advances with every write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg         <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= '0;
            word_index_reg <= '0;
        end else begin
            we_reg <= word_valid;
            if (word_valid) begin
                waddr_reg      <= ADDR_WIDTH'({word_index_reg, 2'b00});
                wdata_reg      <= DATA_WIDTH'(word_data);
                word_index_reg <= word_index_reg + 1'b1;
            end
        end
    end

    // Completion flag rises one cycle after FIN is entered, so the final
    // write strobe always lands while the core is still held in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_reg <= 1'b0;
        end else if (state_reg == FIN) begin
            done_reg <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every header and data byte (not the checksum itself).
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_reg <= '0;
        end else if (byte_fire && (state_reg != CSUM)) begin
            csum_reg <= csum_reg ^ byte_data;
        end
    end
`endif

    assign imem_we    = we_reg;
    assign imem_waddr = waddr_reg;
    assign imem_wdata = wdata_reg;
    assign load_done  = done_reg;
    assign cpu_reset  = ~done_reg;
    assign load_err   = (state_reg == ERROR);

endmodule : imem_boot_loader
